// File: rtl/mem_stream_pkg.sv
// Shared definitions for the 12-port memory stream mux/demux pair: sel code map,
// stream field offsets and the sel-to-port decode.
package mem_stream_pkg;

    localparam int STREAM_W  = 48;
    localparam int PAYLOAD_W = 44;
    localparam int SEL_LSB   = 44;
    localparam int BX_LSB    = 41;
    localparam int BX_W      = 3;

    localparam logic [3:0] SEL_IDLE = 4'b0000;
    localparam logic [3:0] SEL_HDR  = 4'b1111;
    localparam logic [3:0] SEL_P0   = 4'b0001;
    localparam logic [3:0] SEL_P7   = 4'b1000;
    localparam logic [3:0] SEL_P8   = 4'b1001;
    localparam logic [3:0] SEL_P9   = 4'b1011;
    localparam logic [3:0] SEL_P10  = 4'b1100;
    localparam logic [3:0] SEL_P11  = 4'b1101;

    typedef struct packed {
        logic       vld;
        logic [3:0] port;
    } port_sel_t;

    typedef enum logic {
        ST_WAIT_HDR = 1'b0,
        ST_RUN      = 1'b1
    } dmx_state_e;

    // Codes 1010 and 1110 are holes in the map; they decode as not-a-port.
    function automatic port_sel_t sel_to_port(input logic [3:0] sel);
        port_sel_t r;
        r.vld  = 1'b1;
        r.port = 4'd0;
        if (sel >= SEL_P0 && sel <= SEL_P7) begin
            r.port = sel - SEL_P0;
        end else begin
            case (sel)
                SEL_P8:  r.port = 4'd8;
                SEL_P9:  r.port = 4'd9;
                SEL_P10: r.port = 4'd10;
                SEL_P11: r.port = 4'd11;
                default: r.vld  = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_stream_demux_port_addr_ctr.sv
// Per-port write address counter with saturation and sticky overflow.
module port_addr_ctr #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_sat,
    output logic              o_ovf
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_sat;
    logic              r_ovf;

    // r_sat means the top slot is already written; further words are drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_sat  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_clr) begin
            r_addr <= '0;
            r_sat  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_inc) begin
            if (r_sat)
                r_ovf <= 1'b1;
            else if (&r_addr)
                r_sat <= 1'b1;
            else
                r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_sat  = r_sat;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/mem_stream_demux.sv
// Receive-side stream demux: writes 48-bit stream words into 12 memories, tracks BX.
// Optional MEM_STREAM_DEMUX_ERR_EN enables the protocol error counter and BX check.
module mem_stream_demux
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int NPORT  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [STREAM_W-1:0]     stream_in,
    output logic [NPORT-1:0]        wr_en,
    output logic [NPORT*ADDR_W-1:0] wr_addr,
    output logic [PAYLOAD_W-1:0]    wr_dat,
    output logic [BX_W-1:0]         bx_out,
    output logic                    bx_start,
    output logic [NPORT-1:0]        ovf,
    output logic [7:0]              err_cnt
);

    dmx_state_e r_state, w_state_nxt;

    logic [3:0]                   w_sel;
    port_sel_t                    w_ps;
    logic                         w_hdr;
    logic [NPORT-1:0]             w_inc;
    logic [NPORT-1:0]             w_sat;
    logic [NPORT-1:0]             w_wr;
    logic [NPORT-1:0][ADDR_W-1:0] w_addr;

    logic [NPORT-1:0]             r_wr_en;
    logic [NPORT-1:0][ADDR_W-1:0] r_wr_addr;
    logic [PAYLOAD_W-1:0]         r_wr_dat;
    logic [BX_W-1:0]              r_bx;
    logic                         r_bx_start;

    assign w_sel = stream_in[SEL_LSB +: 4];
    assign w_ps  = sel_to_port(w_sel);
    assign w_hdr = (w_sel == SEL_HDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_HDR;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_hdr) w_state_nxt = ST_RUN;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            assign w_inc[gi] = (r_state == ST_RUN) && w_ps.vld && (w_ps.port == 4'(gi));
            assign w_wr[gi]  = w_inc[gi] && !w_sat[gi];

            port_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_hdr),
                .i_inc (w_inc[gi]),
                .o_addr(w_addr[gi]),
                .o_sat (w_sat[gi]),
                .o_ovf (ovf[gi])
            );
        end
    endgenerate

    // wr_addr and wr_dat only move on a write; they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_dat   <= '0;
            r_bx       <= '0;
            r_bx_start <= 1'b0;
        end else begin
            r_wr_en    <= w_wr;
            r_bx_start <= w_hdr;
            if (w_hdr) r_bx <= stream_in[BX_LSB +: BX_W];
            if (|w_wr) r_wr_dat <= stream_in[PAYLOAD_W-1:0];
            for (int i = 0; i < NPORT; i++)
                if (w_wr[i]) r_wr_addr[i] <= w_addr[i];
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_dat   = r_wr_dat;
    assign bx_out   = r_bx;
    assign bx_start = r_bx_start;

`ifdef MEM_STREAM_DEMUX_ERR_EN
    logic       w_illegal;
    logic       w_bx_bad;
    logic       w_drop;
    logic [7:0] r_err;

    // The first header after reset moves WAIT_HDR->RUN, so it is never checked.
    assign w_illegal = !w_ps.vld && !w_hdr && (w_sel != SEL_IDLE);
    assign w_bx_bad  = w_hdr && (r_state == ST_RUN) &&
                       (stream_in[BX_LSB +: BX_W] != r_bx + 3'd1);
    assign w_drop    = |(w_inc & w_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= '0;
        else if ((w_illegal || w_bx_bad || w_drop) && r_err != 8'hFF)
            r_err <= r_err + 8'd1;
    end

    assign err_cnt = r_err;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mem_stream_demux.sv
// Directed plus random stimulus against a per-port word-count reference model.
module tb_mem_stream_demux;

    localparam int AW    = 6;
    localparam int NP    = 12;
    localparam int DEPTH = 1 << AW;
`ifdef MEM_STREAM_DEMUX_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [47:0]       stream_in = '0;
    logic [NP-1:0]     wr_en;
    logic [NP*AW-1:0]  wr_addr;
    logic [43:0]       wr_dat;
    logic [2:0]        bx_out;
    logic              bx_start;
    logic [NP-1:0]     ovf;
    logic [7:0]        err_cnt;

    mem_stream_demux #(.ADDR_W(AW), .NPORT(NP)) dut (
        .clk(clk), .rst_n(rst_n), .stream_in(stream_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .bx_out(bx_out), .bx_start(bx_start), .ovf(ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: words seen per port since the last header.
    bit            m_seen;
    logic [2:0]    m_bx;
    int            m_n[NP];
    logic [NP-1:0] m_en, m_ovf;
    logic          m_start;
    logic [43:0]   m_dat;
    int            m_addr[NP];
    int            m_err;
    // -1 idle, -2 illegal, -3 header, else port number
    int            port_of[16];
    logic [3:0]    sel_of[NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 1'b0; m_bx = '0; m_en = '0; m_ovf = '0; m_start = 1'b0;
        m_dat = '0; m_err = 0;
        for (int i = 0; i < NP; i++) begin m_n[i] = 0; m_addr[i] = 0; end
    endtask

    task automatic err_inc();
        if (ERR && m_err < 255) m_err++;
    endtask

    task automatic model_step(input logic [47:0] w);
        int k;
        k = port_of[w[47:44]];
        m_en = '0;
        m_start = 1'b0;
        if (k == -3) begin
            if (m_seen && int'(w[43:41]) != (int'(m_bx) + 1) % 8) err_inc();
            m_bx = w[43:41];
            m_start = 1'b1;
            m_seen = 1'b1;
            m_ovf = '0;
            for (int i = 0; i < NP; i++) m_n[i] = 0;
        end else if (k >= 0) begin
            if (m_seen) begin
                if (m_n[k] < DEPTH) begin
                    m_en[k] = 1'b1;
                    m_addr[k] = m_n[k];
                    m_dat = w[43:0];
                end else begin
                    m_ovf[k] = 1'b1;
                    err_inc();
                end
                m_n[k]++;
            end
        end else if (k == -2) begin
            err_inc();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_en"},    64'(wr_en),    64'(m_en));
        chk({tag, ".bx_start"}, 64'(bx_start), 64'(m_start));
        chk({tag, ".bx_out"},   64'(bx_out),   64'(m_bx));
        chk({tag, ".ovf"},      64'(ovf),      64'(m_ovf));
        chk({tag, ".err_cnt"},  64'(err_cnt),  64'(m_err));
        chk({tag, ".wr_dat"},   64'(wr_dat),   64'(m_dat));
        for (int i = 0; i < NP; i++)
            if (m_en[i]) chk({tag, ".wr_addr"}, 64'(wr_addr[i*AW +: AW]), 64'(m_addr[i]));
    endtask

    task automatic send(input string tag, input logic [47:0] w);
        @(negedge clk);
        stream_in = w;
        model_step(w);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [43:0] rnd44();
        return 44'({$urandom(), $urandom()});
    endfunction

    function automatic logic [47:0] dw(input logic [3:0] sel);
        return {sel, rnd44()};
    endfunction

    function automatic logic [47:0] hw(input logic [2:0] bx);
        logic [40:0] r;
        r = 41'(rnd44());
        return {4'hF, bx, r};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, ".wr_en"},    64'(wr_en),    64'd0);
        chk({tag, ".wr_addr"},  64'(wr_addr[63:0]), 64'd0);
        chk({tag, ".wr_dat"},   64'(wr_dat),   64'd0);
        chk({tag, ".bx_out"},   64'(bx_out),   64'd0);
        chk({tag, ".bx_start"}, 64'(bx_start), 64'd0);
        chk({tag, ".ovf"},      64'(ovf),      64'd0);
        chk({tag, ".err_cnt"},  64'(err_cnt),  64'd0);
    endtask

    initial begin
        int r, p;
        logic [2:0] b;
        port_of = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, -2, 9, 10, 11, -2, -3};
        sel_of  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                    4'b1001, 4'b1011, 4'b1100, 4'b1101};
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // data before any header is discarded
        send("prehdr", dw(4'b0001));
        send("hdr3", hw(3'd3));
        for (int i = 0; i < 3; i++) send("p0", dw(4'b0001));

        // interleaved ports 8 and 11, then new BX restarts port 8 at 0
        send("hdr4", hw(3'd4));
        send("p8", dw(4'b1001)); send("p11", dw(4'b1101)); send("p11", dw(4'b1101));
        send("p8", dw(4'b1001)); send("p8", dw(4'b1001)); send("idle", 48'd0);
        send("hdr5", hw(3'd5));
        send("p8new", dw(4'b1001));

        // overflow on port 5
        send("hdr6", hw(3'd6));
        for (int i = 0; i < DEPTH + 2; i++) send("p5fill", dw(4'b0110));
        chk("ovf5_set", 64'(ovf[5]), 64'd1);
        send("hdr7", hw(3'd7));
        chk("ovf5_clr", 64'(ovf[5]), 64'd0);

        // illegal codes
        send("p1", dw(4'b0010));
        send("ill_a", dw(4'b1010));
        send("ill_e", dw(4'b1110));
        send("p1b", dw(4'b0010));

        // BX sequence breaks (7->2, 2->6)
        send("hdr2", hw(3'd2));
        send("p2", dw(4'b0011));
        send("hdr6b", hw(3'd6));
        send("p2b", dw(4'b0011));

        // asynchronous reset between port-3 words
        send("hdr7b", hw(3'd7));
        send("p3", dw(4'b0100));
        send("p3", dw(4'b0100));
        #2;
        rst_n = 1'b0;
        stream_in = '0;
        #1;
        check_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send("p3_nohdr", dw(4'b0100));
        send("p3_nohdr2", dw(4'b0100));

        // random traffic
        send("rhdr", hw(3'($urandom_range(0, 7))));
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                b = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : m_bx + 3'd1;
                send("rnd_hdr", hw(b));
            end else if (r < 8) begin
                send("rnd_ill", dw(($urandom_range(0, 1) == 0) ? 4'b1010 : 4'b1110));
            end else if (r < 15) begin
                send("rnd_idle", 48'd0);
            end else if (r < 45) begin
                send("rnd_p4", dw(sel_of[4]));
            end else begin
                p = $urandom_range(0, NP - 1);
                send("rnd_data", dw(sel_of[p]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
